// File: rtl/wash_actuator_driver.sv
// Output stage for the washing-machine controller: drives valves and motor relays
// with dead-time, minimum on-time, valve exclusion, overfill and fill-watchdog protection.
module wash_actuator_driver #(
    parameter int unsigned DEAD_TIME    = 5,
    parameter int unsigned MIN_ON       = 10,
    parameter int unsigned FILL_TIMEOUT = 600,
    parameter int unsigned CNT_W        = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ctrl_fill,
    input  logic       ctrl_release,
    input  logic       ctrl_forward,
    input  logic       ctrl_reverse,
    input  logic       level_full,
    input  logic       fault_clr,
    output logic       valve_in,
    output logic       valve_out,
    output logic       motor_fwd,
    output logic       motor_rev,
    output logic       fault,
    output logic [1:0] fault_code
);

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        REV,
        DEAD
    } motor_state_t;

    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_TIME - 1);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_TIMEOUT - 1);

    motor_state_t     state, state_next;
    logic [CNT_W-1:0] fill_cnt;
    logic [CNT_W-1:0] on_cnt;
    logic [CNT_W-1:0] dead_cnt;

    logic       fwd_req, rev_req;
    logic       motor_conflict, valve_conflict, fill_expire;
    logic       on_done, clear_ok;
    logic [1:0] cause_code;

    always_comb begin
        fwd_req        = ctrl_forward & ~ctrl_reverse;
        rev_req        = ctrl_reverse & ~ctrl_forward;
        motor_conflict = ctrl_forward & ctrl_reverse;
        valve_conflict = ctrl_fill & ctrl_release;
        // Expire on the edge that would bring fill_cnt to FILL_TIMEOUT, so the
        // valve closes on that same edge and stays open exactly FILL_TIMEOUT cycles.
        fill_expire    = valve_in && (fill_cnt == FILL_LAST);
        on_done        = (on_cnt >= ON_LAST);
        clear_ok       = fault && fault_clr && (state == IDLE) &&
                         !(ctrl_fill || ctrl_release || ctrl_forward || ctrl_reverse);

        cause_code = 2'd0;
        if (motor_conflict)      cause_code = 2'd3;
        else if (fill_expire)    cause_code = 2'd2;
        else if (valve_conflict) cause_code = 2'd1;

        state_next = state;
        unique case (state)
            IDLE: begin
                if (!fault) begin
                    if (fwd_req)      state_next = FWD;
                    else if (rev_req) state_next = REV;
                end
            end
            FWD: begin
                if (fault || (!fwd_req && on_done)) state_next = DEAD;
            end
            REV: begin
                if (fault || (!rev_req && on_done)) state_next = DEAD;
            end
            DEAD: begin
                if (dead_cnt == DEAD_LAST) begin
                    if (fault)        state_next = IDLE;
                    else if (fwd_req) state_next = FWD;
                    else if (rev_req) state_next = REV;
                    else              state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fill_cnt   <= '0;
            on_cnt     <= '0;
            dead_cnt   <= '0;
            valve_in   <= 1'b0;
            valve_out  <= 1'b0;
            motor_fwd  <= 1'b0;
            motor_rev  <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'd0;
        end else begin
            state     <= state_next;
            valve_in  <= ctrl_fill & ~ctrl_release & ~level_full & ~fault & ~fill_expire;
            valve_out <= ctrl_release & ~ctrl_fill & ~fault;
            motor_fwd <= (state_next == FWD);
            motor_rev <= (state_next == REV);
            fill_cnt  <= valve_in ? fill_cnt + 1'b1 : '0;

            // on_cnt saturates at MIN_ON-1: beyond that only "done" matters.
            if ((state == FWD || state == REV) && state_next == state)
                on_cnt <= on_done ? on_cnt : on_cnt + 1'b1;
            else
                on_cnt <= '0;

            if (state == DEAD && state_next == DEAD)
                dead_cnt <= dead_cnt + 1'b1;
            else
                dead_cnt <= '0;

            if (fault) begin
                if (clear_ok) begin
                    fault      <= 1'b0;
                    fault_code <= 2'd0;
                end
            end else if (cause_code != 2'd0) begin
                fault      <= 1'b1;
                fault_code <= cause_code;
            end
        end
    end

endmodule

// File: tb/tb_wash_actuator_driver.sv
// Directed self-checking bench for wash_actuator_driver with hand-computed expectations.
module tb_wash_actuator_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse;
    logic       level_full, fault_clr;
    logic       valve_in, valve_out, motor_fwd, motor_rev, fault;
    logic [1:0] fault_code;

    int unsigned n_compared   = 0;
    int unsigned n_mismatched = 0;

    wash_actuator_driver #(
        .DEAD_TIME   (5),
        .MIN_ON      (10),
        .FILL_TIMEOUT(600),
        .CNT_W       (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl_fill   (ctrl_fill),
        .ctrl_release(ctrl_release),
        .ctrl_forward(ctrl_forward),
        .ctrl_reverse(ctrl_reverse),
        .level_full  (level_full),
        .fault_clr   (fault_clr),
        .valve_in    (valve_in),
        .valve_out   (valve_out),
        .motor_fwd   (motor_fwd),
        .motor_rev   (motor_rev),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: inputs set before the call are sampled at the edge, outputs read 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
        check("relay_excl", 32'(motor_fwd & motor_rev), 32'd0);
    endtask

    function automatic logic [31:0] outs();
        return {25'd0, valve_in, valve_out, motor_fwd, motor_rev, fault, fault_code};
    endfunction

    task automatic set_ctrl(input logic f, input logic r, input logic fw, input logic rv);
        ctrl_fill    = f;
        ctrl_release = r;
        ctrl_forward = fw;
        ctrl_reverse = rv;
    endtask

    initial begin
        int unsigned fill_high;

        rst = 1'b1; level_full = 1'b0; fault_clr = 1'b0;
        set_ctrl(1, 1, 1, 1);
        #2;
        for (int i = 0; i < 3; i++) tick();
        check("reset_outs", outs(), 32'd0);

        rst = 1'b0;
        set_ctrl(1, 0, 0, 0);
        tick();
        check("fill_after_reset", outs(), 32'b1000000);
        set_ctrl(0, 0, 0, 0);
        tick();
        check("fill_drop", outs(), 32'd0);

        // Reversal: forward 20 cycles then reverse; fwd high 20, gap 5, then rev.
        for (int i = 0; i < 30; i++) begin
            set_ctrl(0, 0, i < 20, i >= 20);
            tick();
            check("reversal_relays", {30'd0, motor_fwd, motor_rev},
                  {30'd0, 1'(i < 20), 1'(i >= 25)});
        end
        set_ctrl(0, 0, 0, 0);
        for (int i = 0; i < 15; i++) tick();
        check("reversal_settle", outs(), 32'd0);

        // Min on-time: 2-cycle forward pulse holds the relay 10 cycles.
        for (int i = 0; i < 18; i++) begin
            set_ctrl(0, 0, i < 2, 0);
            tick();
            check("min_on_fwd", {30'd0, motor_fwd, motor_rev}, {30'd0, 1'(i < 10), 1'b0});
        end
        check("min_on_nofault", 32'(fault), 32'd0);

        // Fill watchdog.
        fill_high = 0;
        set_ctrl(1, 0, 0, 0);
        for (int i = 0; i < 700; i++) begin
            tick();
            if (!valve_in) break;
            fill_high++;
        end
        check("watchdog_cycles", fill_high, 32'd600);
        check("watchdog_fault", {30'd0, fault, 1'b0}, 32'b10);
        check("watchdog_code", 32'(fault_code), 32'd2);

        set_ctrl(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) tick();
        check("fault_blocks_motor", 32'(motor_fwd), 32'd0);
        fault_clr = 1'b1;
        tick();
        check("clr_ignored_ctrl", {30'd0, fault, 1'b0} | 32'(fault_code), 32'b10 | 32'd2);
        set_ctrl(0, 0, 0, 0);
        tick();
        check("clr_done", outs(), 32'd0);
        fault_clr = 1'b0;

        // Valve conflict latches 1; later motor conflict keeps 1.
        set_ctrl(1, 1, 0, 0);
        tick();
        check("valve_conflict", outs(), 32'b0000101);
        set_ctrl(0, 0, 1, 1);
        tick();
        check("code_held", outs(), 32'b0000101);
        set_ctrl(0, 0, 0, 0);
        fault_clr = 1'b1;
        tick();
        check("clr_conflict", outs(), 32'd0);
        fault_clr = 1'b0;

        // Coincident causes: highest code wins.
        set_ctrl(1, 1, 1, 1);
        tick();
        check("coincide_code3", outs(), 32'b0000111);
        set_ctrl(0, 0, 0, 0);
        fault_clr = 1'b1;
        tick();
        check("clr_code3", outs(), 32'd0);
        fault_clr = 1'b0;

        // Overfill cutoff.
        set_ctrl(1, 0, 0, 0);
        tick();
        check("overfill_open", outs(), 32'b1000000);
        level_full = 1'b1;
        tick();
        check("overfill_close", outs(), 32'd0);
        level_full = 1'b0;
        set_ctrl(0, 0, 0, 0);
        tick();

        // Reset during forward run drops the relay at once.
        set_ctrl(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) tick();
        check("run_fwd", outs(), 32'b0010000);
        rst = 1'b1;
        tick();
        check("reset_mid_run", outs(), 32'd0);
        rst = 1'b0;
        set_ctrl(0, 0, 0, 0);
        tick();
        check("after_reset_idle", outs(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/wash_actuator_driver.md
# wash_actuator_driver

Output stage placed directly downstream of the washing-machine program controller. It consumes the four `ctrl_*` commands, drives the physical fill valve, drain valve and motor direction relays, and enforces the following hardware protections:
- motor dead-time on direction change
- minimum motor on-time
- valve mutual exclusion
- overfill cutoff
- fill watchdog

Any protection violation latches a fault that forces all actuators off until it is cleared.

## Interface
Parameters:
- DEAD_TIME, 5: cycles both motor outputs stay low between any two motor runs (≥1; 500 ms at the 10 Hz system clock)
- MIN_ON, 10: minimum cycles a motor output stays high once asserted (≥1)
- FILL_TIMEOUT, 600: maximum consecutive cycles `valve_in` may stay open (60 s)
- CNT_W, 10: counter width; must hold FILL_TIMEOUT, MIN_ON and DEAD_TIME

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- ctrl_fill  in  1  fill request from program controller
- ctrl_release  in  1  drain request
- ctrl_forward  in  1  motor forward request
- ctrl_reverse  in  1  motor reverse request
- level_full  in  1  drum level sensor (already synchronised); 1 = full
- fault_clr  in  1  fault clear request
- valve_in  out  1  fill valve drive
- valve_out  out  1  drain valve drive
- motor_fwd  out  1  forward relay drive
- motor_rev  out  1  reverse relay drive
- fault  out  1  latched fault flag
- fault_code  out  2  0 = none, 1 = valve conflict, 2 = fill timeout, 3 = motor conflict

## Operation
- All outputs are registered and all counters are CNT_W wide.
- Valves:
  - `valve_in` next = ctrl_fill & ~ctrl_release & ~level_full & ~fault.
  - `valve_out` next = ctrl_release & ~ctrl_fill & ~fault.
  - ctrl_fill & ctrl_release together: both valves close and code 1 is latched.
- Fill watchdog:
  - `fill_cnt` increments on every cycle that `valve_in` = 1 and clears when it is 0.
  - When `fill_cnt` reaches FILL_TIMEOUT, code 2 is latched.
- Motor FSM, states IDLE, FWD, REV, DEAD:
  - Request decoding: fwd_req = ctrl_forward & ~ctrl_reverse; rev_req = the mirror; both high = no request plus code 3 latched.
  - IDLE: fwd_req → FWD, rev_req → REV. Requests are ignored while fault = 1.
  - FWD/REV: `on_cnt` clears on entry and increments each cycle.
  - Exit FWD/REV → DEAD when the same-direction request is absent and on_cnt ≥ MIN_ON-1 (output high exactly MIN_ON cycles minimum).
  - A fault exits FWD/REV → DEAD immediately, overriding MIN_ON.
  - There is no direct FWD↔REV transition.
  - DEAD: `dead_cnt` clears on entry. When dead_cnt = DEAD_TIME-1, next state is FWD on fwd_req, REV on rev_req, else IDLE (fault forces IDLE).
  - Outputs: motor_fwd = (state == FWD), motor_rev = (state == REV); never both high.
- Fault latch:
  - The first cause is latched. If causes coincide, the highest code wins.
  - While latched, later causes do not change fault_code.
  - Clearing requires fault_clr = 1 with all four ctrl_* = 0 and the FSM in IDLE; fault and fault_code return to 0 the next cycle.
  - fault_clr is ignored otherwise.
- Reset:
  - All outputs 0, FSM IDLE, all counters 0, fault cleared.
  - Reset mid-run drops relays and valves on the next edge with no dead-time wait.

## Timing
- Latency: ctrl_* sampled at edge k → outputs change after edge k (visible in cycle k+1).
- Fault detected at edge k: fault = 1 after edge k. All actuators are low after edge k+1 at the latest (valves computed from registered fault; the motor goes through DEAD).
- Direction change with a reversed request already present: the motor output falls, both relays stay low exactly DEAD_TIME cycles, then the opposite relay rises.
- A request dropped before MIN_ON keeps the relay high until MIN_ON cycles total.
- The fill watchdog caps `valve_in` at exactly FILL_TIMEOUT consecutive high cycles.
- level_full closes `valve_in` one cycle after it rises and clears `fill_cnt`.

## Test plan
- Reset: hold rst 3 cycles with all ctrl_* = 1 → all outputs 0, fault_code 0. After release, ctrl_fill = 1, level_full = 0 → valve_in = 1 one cycle later.
- Reversal: forward request for 20 cycles, then switch to reverse → motor_fwd high 20 cycles, both low exactly 5 cycles, then motor_rev = 1; never both high.
- Min on-time: forward pulse of 2 cycles → motor_fwd high exactly 10 cycles, then DEAD for 5, then IDLE.
- Fill watchdog: ctrl_fill held, level_full = 0 → valve_in high exactly 600 cycles, then fault = 1, fault_code = 2. Motor requests are ignored until fault_clr is asserted with ctrl_* = 0.
- Conflicts:
  - ctrl_fill & ctrl_release for 1 cycle → code 1, both valves closed.
  - Then ctrl_forward & ctrl_reverse → code stays 1.
  - Separate run: fill conflict and motor conflict in the same cycle → code 3.
- Overfill and reset mid-run: level_full rises while filling → valve_in = 0 next cycle with no fault. Assert rst during FWD → motor_fwd = 0 next cycle.
